// File: rtl/shift_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// shift_reg_ctrl : frame sequencer for a parallel-load, enable-gated shift reg
// Rev 1.0
// ============================================================================
module shift_reg_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  abort_i,
  output logic                  sr_wr_enable_o,
  output logic [DATA_WIDTH-1:0] sr_wr_data_o,
  output logic                  sr_enable_o,
  output logic                  frame_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int c_CNT_MAX = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_accept;

  // Abort in IDLE wins over the handshake, so no word is taken that cycle.
  assign w_accept = (r_state == S_IDLE) && s_valid_i && !abort_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = '0;
    w_done_nxt     = 1'b0;
    s_ready_o      = 1'b0;
    sr_wr_enable_o = 1'b0;
    sr_enable_o    = 1'b0;
    frame_o        = 1'b0;
    busy_o         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o    = 1'b0;
        s_ready_o = !abort_i;
        if (w_accept) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sr_wr_enable_o = 1'b1;
        w_state_nxt    = abort_i ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        sr_enable_o = 1'b1;
        frame_o     = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_SHIFT_LAST) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort_i || (r_cnt == c_GAP_LAST)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) r_data <= s_data_i;
    end
  end

  assign sr_wr_data_o = r_data;
  assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_shift_reg_ctrl : bench for shift_reg_ctrl, GAP_CYCLES=2 and 0 side by side
// Rev 1.0
// ============================================================================
module tb_shift_reg_ctrl;

  localparam int DW   = 8;
  localparam int GAP0 = 2;
  localparam int GAP1 = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [DW-1:0] data;
  logic          abort;

  wire [1:0]    rdy, wre, sre, frm, bsy, dn;
  wire [DW-1:0] wd [2];

  always #5 clk = ~clk;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP0)) u_dut_gap (
    .clk_i(clk), .a_rst_n_i(rst_n), .s_valid_i(valid), .s_ready_o(rdy[0]),
    .s_data_i(data), .abort_i(abort), .sr_wr_enable_o(wre[0]), .sr_wr_data_o(wd[0]),
    .sr_enable_o(sre[0]), .frame_o(frm[0]), .busy_o(bsy[0]), .done_o(dn[0]));

  shift_reg_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP1)) u_dut_nogap (
    .clk_i(clk), .a_rst_n_i(rst_n), .s_valid_i(valid), .s_ready_o(rdy[1]),
    .s_data_i(data), .abort_i(abort), .sr_wr_enable_o(wre[1]), .sr_wr_data_o(wd[1]),
    .sr_enable_o(sre[1]), .frame_o(frm[1]), .busy_o(bsy[1]), .done_o(dn[1]));

  // Emulated shift registers driven by the controller strobes (MSB first).
  logic [DW-1:0] sreg [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wre[i])      sreg[i] <= wd[i];
      else if (sre[i]) sreg[i] <= {sreg[i][DW-2:0], 1'b0};
    end
  end

  // Reference model: time elapsed since the accepted handshake.
  bit            act  [2];
  int            d    [2];
  logic [DW-1:0] dexp [2];
  bit            dne  [2];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  int            wre_cnt [2], frm_cnt [2], bsy_cnt [2], dn_cnt [2], dn_rdy [2];
  logic [DW-1:0] ser [2];
  bit            pfrm [2];
  int            hs0 [$];
  int            hs1 [$];
  int            fr0 [$];

  function automatic int gapc(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; d[i] = 0; dexp[i] = '0; dne[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit nd;
    for (int i = 0; i < 2; i++) begin
      nd = act[i] && (d[i] == DW) && !abort;
      if (act[i]) begin
        if (abort || d[i] == DW + gapc(i)) act[i] = 0;
        else d[i]++;
      end else if (valid && !abort) begin
        act[i] = 1; d[i] = 0; dexp[i] = data;
      end
      dne[i] = nd;
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      wre_cnt[i] = 0; frm_cnt[i] = 0; bsy_cnt[i] = 0; dn_cnt[i] = 0; dn_rdy[i] = 0;
      ser[i] = '0; pfrm[i] = 0;
    end
    hs0.delete(); hs1.delete(); fr0.delete();
  endtask

  task automatic check_outputs();
    logic [5:0] got, exp;
    bit         e_frm;
    for (int i = 0; i < 2; i++) begin
      e_frm = act[i] && d[i] >= 1 && d[i] <= DW;
      exp   = {!act[i] && !abort, act[i] && d[i] == 0, e_frm, e_frm, act[i], dne[i]};
      got   = {rdy[i], wre[i], sre[i], frm[i], bsy[i], dn[i]};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL ctrl[%0d] cyc %0d: got rdy/wre/sre/frm/bsy/dn=%b want %b", i, cyc, got, exp);
      end
      vecs++;
      if (wd[i] !== dexp[i]) begin
        errs++;
        $display("FAIL wr_data[%0d] cyc %0d: got %h want %h", i, cyc, wd[i], dexp[i]);
      end
      if (e_frm) begin
        vecs++;
        if (sreg[i][DW-1] !== dexp[i][DW-d[i]]) begin
          errs++;
          $display("FAIL serial[%0d] cyc %0d bit %0d: got %b want %b",
                   i, cyc, d[i], sreg[i][DW-1], dexp[i][DW-d[i]]);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] dat, input logic ab);
    valid = v; data = dat; abort = ab;
    #1;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      if (v && rdy[i]) begin
        if (i == 0) hs0.push_back(cyc); else hs1.push_back(cyc);
      end
      if (wre[i]) wre_cnt[i]++;
      if (frm[i]) begin
        frm_cnt[i]++;
        ser[i] = {ser[i][DW-2:0], sreg[i][DW-1]};
        if (!pfrm[i] && i == 0) fr0.push_back(cyc);
      end
      pfrm[i] = frm[i];
      if (bsy[i]) bsy_cnt[i]++;
      if (dn[i]) begin
        dn_cnt[i]++;
        if (rdy[i]) dn_rdy[i]++;
      end
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, DW'($urandom()), 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; data = '0; abort = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
  endtask

  task automatic test_single_frame();
    clear_stats();
    step(1'b1, 8'hA5, 1'b0);
    idle(16);
    vecs++;
    if (wre_cnt[0] != 1) begin errs++; $display("FAIL single_wr_pulses: got %0d want 1", wre_cnt[0]); end
    vecs++;
    if (frm_cnt[0] != DW) begin errs++; $display("FAIL single_frame_len: got %0d want %0d", frm_cnt[0], DW); end
    vecs++;
    if (ser[0] !== 8'hA5) begin errs++; $display("FAIL single_serial: got %h want a5", ser[0]); end
    vecs++;
    if (dn_cnt[0] != 1) begin errs++; $display("FAIL single_done: got %0d want 1", dn_cnt[0]); end
    vecs++;
    if (bsy_cnt[0] != 1 + DW + GAP0) begin
      errs++; $display("FAIL single_busy_len: got %0d want %0d", bsy_cnt[0], 1 + DW + GAP0);
    end
    vecs++;
    if (bsy_cnt[1] != 1 + DW + GAP1) begin
      errs++; $display("FAIL single_busy_len_nogap: got %0d want %0d", bsy_cnt[1], 1 + DW + GAP1);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int k = 0; k < 40 && hs0.size() < 2; k++)
      step(1'b1, (hs0.size() == 0) ? 8'h0F : 8'hF0, 1'b0);
    idle(16);
    vecs++;
    if (hs0.size() != 2) begin
      errs++; $display("FAIL b2b_handshakes: got %0d want 2 (timeout)", hs0.size());
    end else if (hs0[1] - hs0[0] != 2 + DW + GAP0) begin
      errs++; $display("FAIL b2b_spacing: got %0d want %0d", hs0[1] - hs0[0], 2 + DW + GAP0);
    end
    vecs++;
    if (fr0.size() != 2) begin
      errs++; $display("FAIL b2b_frames: got %0d want 2", fr0.size());
    end else if (fr0[1] - fr0[0] - DW != 4) begin
      errs++; $display("FAIL b2b_frame_gap: got %0d want 4", fr0[1] - fr0[0] - DW);
    end
  endtask

  task automatic test_zero_gap();
    clear_stats();
    for (int k = 0; k < 35; k++) step(1'b1, DW'($urandom()), 1'b0);
    idle(16);
    vecs++;
    if (hs1.size() != 4) begin errs++; $display("FAIL zgap_handshakes: got %0d want 4", hs1.size()); end
    for (int k = 1; k < hs1.size(); k++) begin
      vecs++;
      if (hs1[k] - hs1[k-1] != 2 + DW) begin
        errs++; $display("FAIL zgap_period: got %0d want %0d", hs1[k] - hs1[k-1], 2 + DW);
      end
    end
    vecs++;
    if (dn_cnt[1] != 4 || dn_rdy[1] != 4) begin
      errs++; $display("FAIL zgap_done_in_idle: got done=%0d in_idle=%0d want 4/4", dn_cnt[1], dn_rdy[1]);
    end
  endtask

  task automatic test_abort();
    clear_stats();
    step(1'b1, 8'h96, 1'b0);
    idle(4);
    step(1'b0, 8'h00, 1'b1);
    valid = 1'b0; abort = 1'b0;
    #1;
    vecs++;
    if ({frm[0], bsy[0], rdy[0]} !== 3'b001) begin
      errs++; $display("FAIL abort_after: got frm/bsy/rdy=%b want 001", {frm[0], bsy[0], rdy[0]});
    end
    step(1'b1, 8'h55, 1'b1);
    idle(16);
    vecs++;
    if (dn_cnt[0] != 0 || dn_cnt[1] != 0) begin
      errs++; $display("FAIL abort_no_done: got %0d/%0d want 0/0", dn_cnt[0], dn_cnt[1]);
    end
    vecs++;
    if (wre_cnt[0] != 1) begin errs++; $display("FAIL abort_idle_priority: got %0d loads want 1", wre_cnt[0]); end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    step(1'b1, 8'h5A, 1'b0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vecs++;
    if ({frm, bsy, sre} !== 6'b0) begin
      errs++; $display("FAIL rst_mid_async: got frm/bsy/sre=%b want 000000", {frm, bsy, sre});
    end
    check_outputs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    step(1'b1, 8'h3C, 1'b0);
    idle(14);
    vecs++;
    if (ser[0] !== 8'h3C || ser[1] !== 8'h3C) begin
      errs++; $display("FAIL rst_mid_refill: got %h/%h want 3c/3c", ser[0], ser[1]);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    step(1'b1, 8'hC3, 1'b0);
    idle(2);
    for (int k = 0; k < 30 && hs0.size() < 2; k++) step(1'b1, 8'h69, 1'b0);
    idle(15);
    vecs++;
    if (hs0.size() != 2) begin
      errs++; $display("FAIL bp_handshakes: got %0d want 2 (timeout)", hs0.size());
    end else if (hs0[1] - hs0[0] != 2 + DW + GAP0) begin
      errs++; $display("FAIL bp_spacing: got %0d want %0d", hs0[1] - hs0[0], 2 + DW + GAP0);
    end
    vecs++;
    if (wre_cnt[0] != 2 || wre_cnt[1] != 2) begin
      errs++; $display("FAIL bp_loads: got %0d/%0d want 2/2", wre_cnt[0], wre_cnt[1]);
    end
    vecs++;
    if (wd[0] !== 8'h69) begin errs++; $display("FAIL bp_data: got %h want 69", wd[0]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), DW'($urandom()), ($urandom_range(0, 15) == 0));
    idle(16);
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_zero_gap();
    test_abort();
    test_reset_mid_frame();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
